// File: rtl/uart_rx_deserializer.sv
// 8N1 UART receiver with 2-flop synchronizer, one-deep holding register and sticky errors.
// Define UART_RX_PARITY_EN to add an even-parity bit and a live Parity_Err.
module uart_rx_deserializer #(
   parameter int BIT_CLKS = 650
) (
   input  logic       Clock_In,
   input  logic       Reset,
   input  logic       Rx_In,
   output logic [7:0] Rx_Data,
   output logic       Rx_Valid,
   input  logic       Rx_Ready,
   output logic       Frame_Err,
   output logic       Overrun_Err,
   output logic       Parity_Err,
   input  logic       Err_Clr
);

   localparam logic [11:0] HALF = 12'(BIT_CLKS / 2);
   localparam logic [11:0] LAST = 12'(BIT_CLKS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } state_t;

   state_t      state_q, state_d;
   logic        sync1_q, sync2_q, prev_q;
   logic [11:0] cnt_q, cnt_d;
   logic [2:0]  bit_q, bit_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  data_q, data_d;
   logic        valid_q, valid_d;
   logic        ferr_q, ferr_d;
   logic        oerr_q, oerr_d;
   logic        strobe, deliver;
   logic        ferr_set, oerr_set, perr_set;

   always_ff @(posedge Clock_In or negedge Reset) begin
      if (!Reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ferr_q  <= 1'b0;
         oerr_q  <= 1'b0;
      end else begin
         sync1_q <= Rx_In;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ferr_q  <= ferr_d;
         oerr_q  <= oerr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      data_d   = data_q;
      valid_d  = valid_q;
      deliver  = 1'b0;
      ferr_set = 1'b0;
      oerr_set = 1'b0;
      perr_set = 1'b0;
      strobe   = (state_q != IDLE) && (cnt_q == LAST);

      if (state_q != IDLE) begin
         cnt_d = strobe ? 12'd0 : cnt_q + 12'd1;
      end

      unique case (state_q)
         IDLE: begin
            if (prev_q && !sync2_q) begin
               cnt_d   = HALF;
               state_d = START;
            end
         end
         START: begin
            if (strobe) begin
               bit_d   = 3'd0;
               state_d = sync2_q ? IDLE : DATA;
            end
         end
         DATA: begin
            if (strobe) begin
               shift_d = {sync2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (strobe) begin
               perr_set = ^{shift_q, sync2_q};
               state_d  = STOP;
            end
         end
`endif
         STOP: begin
            if (strobe) begin
               ferr_set = !sync2_q;
               deliver  = sync2_q;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (valid_q && Rx_Ready) begin
         valid_d = 1'b0;
      end
      // A full register that is being drained this edge can still take the new byte
      if (deliver) begin
         if (!valid_q || Rx_Ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
         end else begin
            oerr_set = 1'b1;
         end
      end

      ferr_d = ferr_set | (ferr_q & ~Err_Clr);
      oerr_d = oerr_set | (oerr_q & ~Err_Clr);
   end

`ifdef UART_RX_PARITY_EN
   logic perr_q;
   always_ff @(posedge Clock_In or negedge Reset) begin
      if (!Reset) begin
         perr_q <= 1'b0;
      end else begin
         perr_q <= perr_set | (perr_q & ~Err_Clr);
      end
   end
   assign Parity_Err = perr_q;
`else
   logic unused_perr;
   assign unused_perr = perr_set;
   assign Parity_Err  = 1'b0;
`endif

   assign Rx_Data     = data_q;
   assign Rx_Valid    = valid_q;
   assign Frame_Err   = ferr_q;
   assign Overrun_Err = oerr_q;

endmodule
